// File: rtl/stream_ato_radix_parser.sv
// Streaming ASCII-to-integer converter: one byte per beat, radix 2/8/10/16 chosen per string,
// result (value, length, overflow, stopped) presented on a held valid/ready output.
module stream_ato_radix_parser #(
    parameter  int WIDTH   = 32,
    parameter  int MAX_LEN = 64,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [LW-1:0]    out_len,
    output logic             out_overflow,
    output logic             out_stopped,
    output logic [1:0]       dbg_state
);

    // Handshakes: a beat transfers on a rising clk edge where valid & ready are both high;
    // valid never waits on ready, and the DONE result stays stable until out_ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PARSE = 2'd1,
        SKIP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_DEC = 2'b00;
    localparam logic [1:0] MODE_HEX = 2'b01;
    localparam logic [1:0] MODE_OCT = 2'b10;
    localparam logic [1:0] MODE_BIN = 2'b11;

    state_t state;
    state_t state_nx;

    logic [1:0]       mode_q;
    logic [WIDTH-1:0] acc;
    logic [LW-1:0]    len;
    logic             neg;
    logic             overflow;
    logic             stopped;
    logic [WIDTH-1:0] result;

    logic             take;
    logic             active;
    logic             parsing;
    logic [1:0]       cur_mode;
    logic [3:0]       dig_val;
    logic             is_digit;
    logic             is_under;
    logic             is_sign;
    logic             legal;
    logic [4:0]       radix;
    logic [WIDTH+3:0] prod;
    logic [WIDTH-1:0] acc_nx;
    logic             neg_nx;
    logic [LW-1:0]    len_inc;

    assign take     = in_valid && in_ready;
    assign active   = (state == IDLE) || (state == PARSE);
    assign parsing  = take && active;
    // The first byte of a string sees the live mode input; later bytes use the latched copy.
    assign cur_mode = (state == IDLE) ? mode : mode_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, PARSE: begin
                if (take) begin
                    if (in_last) begin
                        state_nx = DONE;
                    end else if (!legal) begin
                        state_nx = SKIP;
                    end else begin
                        state_nx = PARSE;
                    end
                end
            end
            SKIP: begin
                if (take && in_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state != DONE) && !rst;
        out_valid = (state == DONE);
        dbg_state = state;
    end

    // Character classification
    always_comb begin
        dig_val  = 4'd0;
        is_digit = 1'b0;
        if (in_data >= "0" && in_data <= "9") begin
            dig_val = in_data[3:0];
            case (cur_mode)
                MODE_DEC, MODE_HEX: is_digit = 1'b1;
                MODE_OCT:           is_digit = (in_data <= "7");
                MODE_BIN:           is_digit = (in_data <= "1");
                default:            is_digit = 1'b0;
            endcase
        end else if ((in_data >= "a" && in_data <= "f") || (in_data >= "A" && in_data <= "F")) begin
            dig_val  = in_data[3:0] + 4'd9;
            is_digit = (cur_mode == MODE_HEX);
        end
        is_under = (in_data == "_");
        is_sign  = (in_data == "-") && (state == IDLE) && (cur_mode == MODE_DEC);
        legal    = is_digit || is_under || is_sign;
    end

    always_comb begin
        case (cur_mode)
            MODE_DEC: radix = 5'd10;
            MODE_HEX: radix = 5'd16;
            MODE_OCT: radix = 5'd8;
            default:  radix = 5'd2;
        endcase
    end

    // Four guard bits hold everything that can spill out of one acc*R + d step.
    assign prod    = {4'b0000, acc} * (WIDTH + 4)'(radix) + (WIDTH + 4)'(dig_val);
    assign len_inc = (len == LW'(MAX_LEN)) ? len : len + LW'(1);

    always_comb begin
        acc_nx = acc;
        neg_nx = neg;
        if (parsing && is_digit) begin
            acc_nx = prod[WIDTH-1:0];
        end
        if (parsing && is_sign) begin
            neg_nx = 1'b1;
        end
    end

    // Datapath: accumulation, flags and the held result
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_DEC;
            acc      <= '0;
            len      <= '0;
            neg      <= 1'b0;
            overflow <= 1'b0;
            stopped  <= 1'b0;
            result   <= '0;
        end else if (state == DONE) begin
            if (out_ready) begin
                acc      <= '0;
                len      <= '0;
                neg      <= 1'b0;
                overflow <= 1'b0;
                stopped  <= 1'b0;
                result   <= '0;
            end
        end else if (take) begin
            if (state == IDLE) begin
                mode_q <= mode;
            end
            if (parsing) begin
                acc <= acc_nx;
                neg <= neg_nx;
                if (is_digit) begin
                    overflow <= overflow || (prod[WIDTH+3:WIDTH] != 4'd0);
                end
                if (legal) begin
                    len <= len_inc;
                end else begin
                    stopped <= 1'b1;
                end
            end
            if (in_last) begin
                result <= neg_nx ? (~acc_nx + WIDTH'(1)) : acc_nx;
            end
        end
    end

    assign out_value    = result;
    assign out_len      = len;
    assign out_overflow = overflow;
    assign out_stopped  = stopped;

endmodule

// File: tb/tb_stream_ato_radix_parser.sv
// Bench for stream_ato_radix_parser: directed cases plus random strings scored against
// an arithmetic model of the conversion rules.
module tb_stream_ato_radix_parser;

    localparam int WIDTH   = 32;
    localparam int MAX_LEN = 64;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [LW-1:0]    out_len;
    logic             out_overflow;
    logic             out_stopped;
    logic [1:0]       dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [7:0]       bq[$];

    stream_ato_radix_parser #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_len(out_len), .out_overflow(out_overflow), .out_stopped(out_stopped),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model
    function automatic int digit_of(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    function automatic void model(input logic [1:0] m, input logic [7:0] b[$],
                                  output logic [31:0] v, output int l,
                                  output logic o, output logic st);
        longint acc = 0;
        bit neg = 0;
        int radix;
        int d;
        radix = (m == 2'b00) ? 10 : (m == 2'b01) ? 16 : (m == 2'b10) ? 8 : 2;
        l = 0;
        o = 1'b0;
        st = 1'b0;
        foreach (b[i]) begin
            if (st) continue;
            d = digit_of(b[i]);
            if (d >= 0 && d < radix) begin
                acc = acc * radix + d;
                if ((acc >> 32) != 0) o = 1'b1;
                acc = acc & 64'h0000_0000_FFFF_FFFF;
                if (l < MAX_LEN) l++;
            end else if (b[i] == "_") begin
                if (l < MAX_LEN) l++;
            end else if (b[i] == "-" && i == 0 && m == 2'b00) begin
                neg = 1;
                if (l < MAX_LEN) l++;
            end else begin
                st = 1'b1;
            end
        end
        v = neg ? 32'(-acc) : 32'(acc);
    endfunction

    function automatic void load(input string s);
        bq.delete();
        for (int i = 0; i < s.len(); i++) bq.push_back(8'(s[i]));
    endfunction

    // Driver: called and returns on a negedge; the byte transfers on the posedge in between.
    task automatic drive_byte(input logic [7:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_str(input logic [1:0] m, input logic [7:0] b[$], input string tag,
                           input int hold, output logic [31:0] v, output logic [LW-1:0] l,
                           output logic o, output logic st);
        logic [31:0] ev;
        int el;
        logic eo;
        logic est;
        model(m, b, ev, el, eo, est);
        exp_q.push_back(ev);
        mode = m;
        foreach (b[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_byte(b[i], i == b.size() - 1);
            if (i == 0) mode = 2'($urandom);
            if (i != b.size() - 1) check({tag, "_early_valid"}, out_valid, 0);
        end
        check({tag, "_latency"}, out_valid, 1);
        check({tag, "_ready_done"}, in_ready, 0);
        v  = out_value;
        l  = out_len;
        o  = out_overflow;
        st = out_stopped;
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_value"}, out_value, v);
            check({tag, "_hold_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_consumed"}, out_valid, 0);
        check({tag, "_value"}, v, exp_q.pop_front());
        check({tag, "_len"}, l, el);
        check({tag, "_ovf"}, o, eo);
        check({tag, "_stop"}, st, est);
    endtask

    task automatic dir(input logic [1:0] m, input string s, input logic [31:0] cv, input int cl,
                       input logic co, input logic cst, input int hold);
        logic [31:0] v;
        logic [LW-1:0] l;
        logic o;
        logic st;
        load(s);
        run_str(m, bq, s, hold, v, l, o, st);
        check({s, "_const_value"}, v, cv);
        check({s, "_const_len"}, l, cl);
        check({s, "_const_ovf"}, o, co);
        check({s, "_const_stop"}, st, cst);
    endtask

    initial begin
        string pool;
        string long_s;
        logic [31:0] v;
        logic [LW-1:0] l;
        logic o;
        logic st;
        int n;

        rst = 1'b1;
        mode = 2'b00;
        in_valid = 1'b0;
        in_data = 8'd0;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_value", out_value, 0);
        check("rst_len", out_len, 0);
        check("rst_ovf", out_overflow, 0);
        check("rst_stop", out_stopped, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_state", dbg_state, 0);

        dir(2'b00, "123", 32'd123, 3, 1'b0, 1'b0, 1);
        dir(2'b01, "fF_1", 32'h0000_0FF1, 4, 1'b0, 1'b0, 0);
        dir(2'b11, "1_01", 32'd5, 4, 1'b0, 1'b0, 2);
        dir(2'b00, "-42", 32'hFFFF_FFD6, 3, 1'b0, 1'b0, 0);
        dir(2'b01, "-1", 32'd0, 0, 1'b0, 1'b1, 0);
        dir(2'b00, "12a34", 32'd12, 2, 1'b0, 1'b1, 0);
        dir(2'b00, "4294967296", 32'd0, 10, 1'b1, 1'b0, 0);
        dir(2'b10, "37777777777", 32'hFFFF_FFFF, 11, 1'b0, 1'b0, 0);
        dir(2'b00, "7", 32'd7, 1, 1'b0, 1'b0, 3);
        dir(2'b00, "-", 32'd0, 1, 1'b0, 1'b0, 0);
        dir(2'b10, "8", 32'd0, 0, 1'b0, 1'b1, 0);
        dir(2'b00, "5-", 32'd5, 1, 1'b0, 1'b1, 0);
        long_s = "";
        for (int i = 0; i < 70; i++) long_s = {long_s, "_"};
        long_s = {long_s, "7"};
        dir(2'b00, long_s, 32'd7, MAX_LEN, 1'b0, 1'b0, 0);

        // Reset mid-string, with a last beat presented during the reset cycle
        mode = 2'b00;
        drive_byte("9", 1'b0);
        drive_byte("8", 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = "7";
        in_last = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        check("midrst_no_result", out_valid, 0);
        check("midrst_state", dbg_state, 0);
        dir(2'b00, "5", 32'd5, 1, 1'b0, 1'b0, 0);

        // Random strings
        pool = "0123456789abcdefABCDEF__--xZ 9";
        for (int t = 0; t < 200; t++) begin
            bq.delete();
            n = $urandom_range(1, 14);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) != 0)
                    bq.push_back(8'(pool[$urandom_range(0, 9)]));
                else
                    bq.push_back(8'(pool[$urandom_range(0, pool.len() - 1)]));
            end
            run_str(2'($urandom), bq, "rnd", $urandom_range(0, 3), v, l, o, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
